// File: rtl/itr_ctrl_pkg.sv
// Shared definitions for the interrupt controller: FSM state encoding and
// the width helper used for source ids.
package itr_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIRE = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_e;

  function automatic int unsigned id_width(input int unsigned n);
    int unsigned w;
    if (n > 1) w = $clog2(n);
    else       w = 1;
    return w;
  endfunction

endpackage

// File: rtl/itr_ctrl_irq_pend.sv
// Rising-edge detector and pending register; a new edge wins over a
// same-cycle clear so a re-asserted source is never lost.
module irq_pend
  import itr_ctrl_pkg::*;
#(
  parameter int unsigned NUIRQS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUIRQS-1:0] irq_src,
  input  logic [NUIRQS-1:0] clr,
  output logic [NUIRQS-1:0] pending
);

  logic [NUIRQS-1:0] prev_q;
  logic [NUIRQS-1:0] pend_q, pend_d;
  logic [NUIRQS-1:0] rise;

  assign rise   = irq_src & ~prev_q;
  assign pend_d = (pend_q & ~clr) | rise;

  // prev loads irq_src even in reset so a line held high across reset
  // release does not look like an edge.
  always_ff @(posedge clk) begin
    prev_q <= irq_src;
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

  assign pending = pend_q;

endmodule

// File: rtl/itr_ctrl.sv
// Interrupt controller for the core's single itr input: pending/mask
// registers, lowest-index priority select and an itr/ack/hold-off sequencer.
module itr_ctrl
  import itr_ctrl_pkg::*;
#(
  parameter int unsigned NUBITS = 32,
  parameter int unsigned NUIRQS = 4,
  parameter int unsigned NUIOIN = 8,
  parameter int unsigned NUIOOU = 8,
  parameter int unsigned AD_MSK = 6,
  parameter int unsigned AD_ACK = 7,
  parameter int unsigned AD_ID  = 6,
  parameter int unsigned AD_PND = 7,
  parameter int unsigned HOLDOF = 2,
  localparam int unsigned AOW = (NUIOOU > 1) ? $clog2(NUIOOU) : 1,
  localparam int unsigned AIW = (NUIOIN > 1) ? $clog2(NUIOIN) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUIRQS-1:0] irq_src,
  input  logic              out_en,
  input  logic [AOW-1:0]    addr_out,
  input  logic [NUBITS-1:0] data_out,
  input  logic              req_in,
  input  logic [AIW-1:0]    addr_in,
  output logic [NUBITS-1:0] io_rdata,
  output logic              io_hit,
  output logic              itr,
  output logic              busy
);

  localparam int unsigned IDW = id_width(NUIRQS);
  localparam int unsigned HW  = $clog2(HOLDOF + 1);

  // Single-address port spaces decode against 0.
  localparam logic [AOW-1:0] MSK_A = (NUIOOU > 1) ? AOW'(AD_MSK) : '0;
  localparam logic [AOW-1:0] ACK_A = (NUIOOU > 1) ? AOW'(AD_ACK) : '0;
  localparam logic [AIW-1:0] ID_A  = (NUIOIN > 1) ? AIW'(AD_ID)  : '0;
  localparam logic [AIW-1:0] PND_A = (NUIOIN > 1) ? AIW'(AD_PND) : '0;
  localparam logic [HW-1:0]  HOLD_LD = HW'(HOLDOF - 1);

  state_e            state_q, state_d;
  logic [IDW-1:0]    cur_id_q, cur_id_d;
  logic [HW-1:0]     cnt_q, cnt_d;
  logic [NUIRQS-1:0] mask_q, mask_d;
  logic [NUIRQS-1:0] pending, active, clr;
  logic [IDW-1:0]    sel_id;
  logic              msk_wr, ack_wr;

  irq_pend #(.NUIRQS(NUIRQS)) u_pend (
    .clk     (clk),
    .rst     (rst),
    .irq_src (irq_src),
    .clr     (clr),
    .pending (pending)
  );

  assign msk_wr = out_en && (addr_out == MSK_A);
  assign ack_wr = out_en && (addr_out == ACK_A);
  assign mask_d = msk_wr ? data_out[NUIRQS-1:0] : mask_q;
  assign active = pending & mask_q;

  generate
    if (NUBITS > NUIRQS) begin : g_unused
      logic unused_data;
      assign unused_data = ^data_out[NUBITS-1:NUIRQS];
    end
  endgenerate

  always_comb begin
    logic found;
    sel_id = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < NUIRQS; i++) begin
      if (active[i] && !found) begin
        sel_id = IDW'(i);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cur_id_d = cur_id_q;
    cnt_d    = cnt_q;
    clr      = '0;
    itr      = 1'b0;
    busy     = 1'b0;
    case (state_q)
      IDLE: begin
        if (|active) begin
          cur_id_d = sel_id;
          state_d  = FIRE;
        end
      end
      FIRE: begin
        itr     = 1'b1;
        busy    = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (ack_wr) begin
          for (int unsigned i = 0; i < NUIRQS; i++)
            clr[i] = (cur_id_q == IDW'(i));
          cnt_d   = HOLD_LD;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - HW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cur_id_q <= '0;
      cnt_q    <= '0;
      mask_q   <= '0;
    end else begin
      state_q  <= state_d;
      cur_id_q <= cur_id_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
    end
  end

  always_comb begin
    io_rdata = '0;
    io_hit   = 1'b0;
    if (req_in) begin
      if (addr_in == ID_A) begin
        io_rdata = NUBITS'(cur_id_q);
        io_hit   = 1'b1;
      end else if (addr_in == PND_A) begin
        io_rdata = NUBITS'(pending);
        io_hit   = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_itr_ctrl.sv
// Directed bench for itr_ctrl with hand-computed expectations.
module tb_itr_ctrl;

  localparam logic [2:0] A_MSK = 3'd6;
  localparam logic [2:0] A_ACK = 3'd7;
  localparam logic [2:0] A_ID  = 3'd6;
  localparam logic [2:0] A_PND = 3'd7;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  irq_src;
  logic        out_en;
  logic [2:0]  addr_out;
  logic [31:0] data_out;
  logic        req_in;
  logic [2:0]  addr_in;
  logic [31:0] io_rdata;
  logic        io_hit;
  logic        itr;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  itr_ctrl #(
    .NUBITS(32), .NUIRQS(4), .NUIOIN(8), .NUIOOU(8),
    .AD_MSK(6), .AD_ACK(7), .AD_ID(6), .AD_PND(7), .HOLDOF(2)
  ) dut (
    .clk(clk), .rst(rst), .irq_src(irq_src),
    .out_en(out_en), .addr_out(addr_out), .data_out(data_out),
    .req_in(req_in), .addr_in(addr_in),
    .io_rdata(io_rdata), .io_hit(io_hit), .itr(itr), .busy(busy)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d, output logic h);
    req_in  = 1'b1;
    addr_in = a;
    #1;
    d = io_rdata;
    h = io_hit;
    req_in = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    out_en   = 1'b1;
    addr_out = a;
    data_out = d;
    @(negedge clk);
    out_en   = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic h;
    rst = 1'b1; irq_src = 4'b0010; out_en = 1'b0; addr_out = '0; data_out = '0;
    req_in = 1'b0; addr_in = '0;
    repeat (3) step();
    checks++; if (itr !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_out itr=%b busy=%b exp 0 0", itr, busy); end
    rst = 1'b0;
    wr(A_MSK, 32'hF);
    for (int i = 0; i < 10; i++) begin
      rd(A_PND, d, h);
      checks++; if (itr !== 1'b0 || d !== 32'd0) begin errors++; $display("FAIL rst_noevt cyc %0d itr=%b pnd=%h exp 0 0", i, itr, d); end
      step();
    end
    rd(A_ID, d, h);
    checks++; if (d !== 32'd0 || h !== 1'b1) begin errors++; $display("FAIL rst_id got %h hit %b exp 0 1", d, h); end
    rd(3'd0, d, h);
    checks++; if (d !== 32'd0 || h !== 1'b0) begin errors++; $display("FAIL miss_rd got %h hit %b exp 0 0", d, h); end
    irq_src = 4'b0000;
    step();
  endtask

  task automatic test_dispatch();
    logic [31:0] d; logic h;
    irq_src = 4'b0100; step(); irq_src = 4'b0000;
    checks++; if (itr !== 1'b0) begin errors++; $display("FAIL disp_n1 itr=%b exp 0", itr); end
    step();
    rd(A_ID, d, h);
    checks++; if (itr !== 1'b1 || busy !== 1'b1 || d !== 32'd2 || h !== 1'b1) begin
      errors++; $display("FAIL disp_n2 itr=%b busy=%b id=%0d hit=%b exp 1 1 2 1", itr, busy, d, h); end
    step();
    checks++; if (itr !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL disp_n3 itr=%b busy=%b exp 0 1", itr, busy); end
    repeat (3) step();
    checks++; if (busy !== 1'b1 || itr !== 1'b0) begin errors++; $display("FAIL disp_wait busy=%b itr=%b exp 1 0", busy, itr); end
    wr(A_ACK, 32'd0);
    rd(A_PND, d, h);
    checks++; if (busy !== 1'b0 || d !== 32'd0) begin errors++; $display("FAIL disp_ack busy=%b pnd=%h exp 0 0", busy, d); end
    repeat (3) step();
  endtask

  task automatic test_priority();
    logic [31:0] d; logic h;
    irq_src = 4'b1010; step(); irq_src = 4'b0000;
    checks++; if (itr !== 1'b0) begin errors++; $display("FAIL prio_n1 itr=%b exp 0", itr); end
    step();
    rd(A_ID, d, h);
    checks++; if (itr !== 1'b1 || d !== 32'd1) begin errors++; $display("FAIL prio_first itr=%b id=%0d exp 1 1", itr, d); end
    rd(A_PND, d, h);
    checks++; if (d !== 32'hA) begin errors++; $display("FAIL prio_pnd got %h exp a", d); end
    step();
    wr(A_ACK, 32'd0);
    rd(A_PND, d, h);
    checks++; if (itr !== 1'b0 || busy !== 1'b0 || d !== 32'h8) begin
      errors++; $display("FAIL prio_h1 itr=%b busy=%b pnd=%h exp 0 0 8", itr, busy, d); end
    step();
    checks++; if (itr !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL prio_h2 itr=%b busy=%b exp 0 0", itr, busy); end
    step();
    checks++; if (itr !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL prio_idle itr=%b busy=%b exp 0 0", itr, busy); end
    step();
    rd(A_ID, d, h);
    checks++; if (itr !== 1'b1 || d !== 32'd3) begin errors++; $display("FAIL prio_second itr=%b id=%0d exp 1 3", itr, d); end
    step();
    wr(A_ACK, 32'd0);
    repeat (4) step();
    rd(A_PND, d, h);
    checks++; if (itr !== 1'b0 || busy !== 1'b0 || d !== 32'd0) begin
      errors++; $display("FAIL prio_done itr=%b busy=%b pnd=%h exp 0 0 0", itr, busy, d); end
  endtask

  task automatic test_masked();
    logic [31:0] d; logic h;
    wr(A_MSK, 32'h0);
    irq_src = 4'b0001; step(); irq_src = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (itr !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mask_hold cyc %0d itr=%b busy=%b exp 0 0", i, itr, busy); end
    end
    rd(A_PND, d, h);
    checks++; if (d !== 32'd1 || h !== 1'b1) begin errors++; $display("FAIL mask_pnd got %h hit %b exp 1 1", d, h); end
    wr(A_MSK, 32'h1);
    checks++; if (itr !== 1'b0) begin errors++; $display("FAIL mask_m1 itr=%b exp 0", itr); end
    step();
    rd(A_ID, d, h);
    checks++; if (itr !== 1'b1 || d !== 32'd0) begin errors++; $display("FAIL mask_fire itr=%b id=%0d exp 1 0", itr, d); end
  endtask

  task automatic test_ack_edge();
    logic [31:0] d; logic h;
    step();
    out_en = 1'b1; addr_out = A_ACK; data_out = '0; irq_src = 4'b0001;
    step();
    out_en = 1'b0; irq_src = 4'b0000;
    rd(A_PND, d, h);
    checks++; if (d !== 32'd1 || busy !== 1'b0) begin errors++; $display("FAIL ackedge_pnd pnd=%h busy=%b exp 1 0", d, busy); end
    step(); step();
    checks++; if (itr !== 1'b0) begin errors++; $display("FAIL ackedge_idle itr=%b exp 0", itr); end
    step();
    rd(A_ID, d, h);
    checks++; if (itr !== 1'b1 || d !== 32'd0) begin errors++; $display("FAIL ackedge_refire itr=%b id=%0d exp 1 0", itr, d); end
  endtask

  task automatic test_reset_wait();
    logic [31:0] d; logic h;
    step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rw_inwait busy=%b exp 1", busy); end
    rst = 1'b1; step(); rst = 1'b0;
    rd(A_PND, d, h);
    checks++; if (itr !== 1'b0 || busy !== 1'b0 || d !== 32'd0) begin
      errors++; $display("FAIL rw_state itr=%b busy=%b pnd=%h exp 0 0 0", itr, busy, d); end
    rd(A_ID, d, h);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL rw_id got %0d exp 0", d); end
    irq_src = 4'b0010; step(); irq_src = 4'b0000; step();
    wr(A_ACK, 32'd0);
    rd(A_PND, d, h);
    checks++; if (d !== 32'd2) begin errors++; $display("FAIL rw_ackign pnd=%h exp 2", d); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (itr !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rw_masked cyc %0d itr=%b busy=%b exp 0 0", i, itr, busy); end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_dispatch();
    test_priority();
    test_masked();
    test_ack_edge();
    test_reset_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/itr_ctrl.md
Name: itr_ctrl

Overview:
Interrupt controller for the processor core's single `itr` input.
- Collects NUIRQS external request lines, latches rising edges as pending, masks them and picks the lowest-index active source.
- Sequences exactly one `itr` pulse per dispatched source, then waits for a software acknowledge.
- Sits beside the core on its I/O bus: the core programs the mask and acknowledges through output port writes, and reads the source id through input port reads.

Parameters:
- NUBITS, 32, core data width.
- NUIRQS, 4, number of interrupt sources (1..NUBITS).
- NUIOIN, 8, number of core input port addresses.
- NUIOOU, 8, number of core output port addresses.
- AD_MSK, 6, output port address that writes the mask register.
- AD_ACK, 7, output port address that acknowledges the current interrupt.
- AD_ID, 6, input port address that returns the current source id.
- AD_PND, 7, input port address that returns the pending vector.
- HOLDOF, 2, idle cycles enforced after an acknowledge before the next dispatch (>=1).

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- irq_src, input, NUIRQS, request lines, synchronous to clk, rising-edge sensitive.
- out_en, input, 1, core output-port write strobe.
- addr_out, input, $clog2(NUIOOU), core output-port address.
- data_out, input, NUBITS, core output data.
- req_in, input, 1, core input-port read request.
- addr_in, input, $clog2(NUIOIN), core input-port address.
- io_rdata, output, NUBITS, read data returned to the core.
- io_hit, output, 1, high when req_in targets AD_ID or AD_PND; steers the top-level io_in mux.
- itr, output, 1, one-cycle interrupt pulse to the core.
- busy, output, 1, high from dispatch until acknowledge.

Behaviour:
- Single clock domain: all state on posedge clk.
- Reset (synchronous, rst=1):
  - pending=0, mask=0 (all sources masked), cur_id=0, state=IDLE, hold counter=0, itr=0, busy=0.
  - The edge register loads irq_src, so a line already high at reset release produces no event.
- Edge detect:
  - edge[i] = irq_src[i] & ~prev[i]; prev <= irq_src every cycle.
  - edge[i] sets pending[i] next cycle.
- Mask:
  - Mask write: out_en & addr_out==AD_MSK loads mask <= data_out[NUIRQS-1:0].
  - The mask only gates dispatch; masked edges still set pending.
- Active vector: active = pending & mask.
- FSM states IDLE, FIRE, WAIT, HOLD:
  - IDLE: if active!=0, cur_id <= lowest set index of active, go to FIRE.
  - FIRE: itr=1 for this single cycle, busy=1, go to WAIT.
  - WAIT: busy=1. When out_en & addr_out==AD_ACK, clear pending[cur_id], load the hold counter with HOLDOF-1, go to HOLD. Nothing else leaves WAIT; an unacknowledged interrupt blocks forever.
  - HOLD: busy=0, itr=0. Decrement the counter; at 0 go to IDLE.
- Latency: an edge at cycle n gives pending at n+1, FIRE (itr high) at n+2 if unmasked and the FSM is IDLE.
- Preemption: none. A higher-priority source arriving in WAIT is held pending and dispatched after HOLD.
- Simultaneous ack clear and new edge on the same bit: set wins, pending stays 1 and the source re-dispatches after HOLD.
- Acknowledge outside WAIT: ignored, no pending change.
- Mask write in the same cycle as IDLE selection: selection uses the old mask.
- Mask cleared while in WAIT: the current interrupt still requires an acknowledge.
- Reads (combinational, while req_in=1):
  - AD_ID: io_rdata = zero-extended cur_id, io_hit=1.
  - AD_PND: io_rdata = zero-extended pending, io_hit=1.
  - Otherwise io_rdata=0, io_hit=0.
- Reads have no side effects.
- Widths: cur_id is max(1,$clog2(NUIRQS)) bits. When NUIOOU or NUIOIN is 1, the corresponding address port is 1 bit and the decodes compare against 0.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE=2'd0, FIRE=2'd1, WAIT=2'd2, HOLD=2'd3.
  - The id-width function max(1,$clog2(n)).
- One sub-module, `irq_pend`: edge detector plus pending register with set-over-clear priority, parameterised by NUIRQS.
- The priority encoder and FSM stay in itr_ctrl.

Test Plan:
- Reset with irq_src=4'b0010 held high, mask=4'hF, then release -> no itr, pending=0 for 10 cycles.
- Write mask=4'hF, pulse irq_src[2] at cycle n -> itr high only at n+2; read AD_ID returns 2; busy high until ack.
- Pulse irq_src[3] and irq_src[1] together -> id 1 dispatched first; ack; after HOLDOF=2 idle cycles itr pulses with id 3.
- mask=4'b0000, pulse irq_src[0] -> AD_PND reads 1, no itr; write mask=4'b0001 -> itr two cycles later.
- In WAIT on id 0, pulse irq_src[0] in the same cycle as ack -> pending[0] stays 1; source 0 re-fires after HOLD.
- Assert rst during WAIT -> next cycle itr=0, busy=0, pending=0, mask=0; a later ack write is ignored.
